// File: rtl/ledpanel_pkg.sv
// Shared geometry, scan-state encoding and bitplane helper for the HUB75 panel driver.
package ledpanel_pkg;

    localparam int unsigned COLS      = 32;
    localparam int unsigned ROWS      = 16;
    localparam int unsigned SCAN_ROWS = 8;
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned COL_W     = $clog2(COLS);
    localparam int unsigned ROW_W     = $clog2(SCAN_ROWS);
    localparam int unsigned IDX_W     = ROW_W + COL_W;

    typedef enum logic [1:0] {
        FETCH,
        SHIFT,
        LATCH,
        SHOW
    } scan_state_e;

    // Picks one bit of each 8-bit channel of a {r,g,b} pixel.
    function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix,
                                              input logic [2:0]       bit_idx);
        logic [PIX_W-1:0] s;
        s = pix >> bit_idx;
        return {s[16], s[8], s[0]};
    endfunction

endpackage

// File: rtl/panel_fb_ram.sv
// Double-buffered framebuffer: 2 buffers x 256 words of {top,bottom} pixels,
// per-half write enable, synchronous read-first read port.
module panel_fb_ram
    import ledpanel_pkg::*;
(
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic               wr_buf_i,
    input  logic               wr_bot_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [PIX_W-1:0]   wr_data_i,
    input  logic               rd_buf_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [2*PIX_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 * (1 << IDX_W);

    logic [2*PIX_W-1:0] mem_q [DEPTH];
    logic [2*PIX_W-1:0] rd_data_q;
    logic [IDX_W:0]     wr_a;
    logic [IDX_W:0]     rd_a;

    assign wr_a = {wr_buf_i, wr_idx_i};
    assign rd_a = {rd_buf_i, rd_idx_i};

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_bot_i) begin
                mem_q[wr_a][PIX_W-1:0] <= wr_data_i;
            end else begin
                mem_q[wr_a][2*PIX_W-1:PIX_W] <= wr_data_i;
            end
        end
        rd_data_q <= mem_q[rd_a];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hub75_scanout.sv
// HUB75 1/8-scan driver: framebuffer write port plus BCM scan FSM and
// registered panel pins.
module hub75_scanout
    import ledpanel_pkg::*;
#(
    parameter int unsigned BITS       = 4,
    parameter int unsigned BASE_TICKS = 8
) (
    input  logic              pixclk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_rgb,
    input  logic              wr_en,
    input  logic              display,
    output logic [2:0]        rgb_top,
    output logic [2:0]        rgb_bot,
    output logic [2:0]        row_addr,
    output logic              panel_clk,
    output logic              panel_lat,
    output logic              panel_oe_n,
    output logic              frame_done
);

    localparam int unsigned SHOW_W  = BITS + $clog2(BASE_TICKS);
    localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;

    scan_state_e          state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic [SHOW_W-1:0]    show_cnt_q, show_cnt_d;
    logic                 half_q, half_d;
    logic                 front_q, front_d;
    logic [2:0]           rgb_top_q, rgb_top_d;
    logic [2:0]           rgb_bot_q, rgb_bot_d;
    logic [2:0]           row_addr_q, row_addr_d;
    logic                 clk_q, clk_d;
    logic                 lat_q, lat_d;
    logic                 oe_n_q, oe_n_d;
    logic                 done_q, done_d;

    logic [COL_W-1:0]     rd_col;
    logic [2*PIX_W-1:0]   rd_data;
    logic [SHOW_W-1:0]    show_len;
    logic [2:0]           bit_idx;

    panel_fb_ram u_ram (
        .clk_i     (pixclk),
        .wr_en_i   (wr_en),
        .wr_buf_i  (display),
        .wr_bot_i  (wr_addr[ADDR_W-1]),
        .wr_idx_i  (wr_addr[IDX_W-1:0]),
        .wr_data_i (wr_rgb),
        .rd_buf_i  (front_q),
        .rd_idx_i  ({row_q, rd_col}),
        .rd_data_o (rd_data)
    );

    assign show_len = SHOW_W'(BASE_TICKS) << plane_q;
    assign bit_idx  = 3'(8 - BITS) + 3'(plane_q);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        plane_d    = plane_q;
        show_cnt_d = show_cnt_q;
        half_d     = half_q;
        front_d    = front_q;
        rgb_top_d  = rgb_top_q;
        rgb_bot_d  = rgb_bot_q;
        row_addr_d = row_addr_q;
        clk_d      = 1'b0;
        lat_d      = 1'b0;
        oe_n_d     = 1'b1;
        done_d     = 1'b0;
        rd_col     = '0;

        unique case (state_q)
            FETCH: begin
                col_d   = '0;
                half_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Prefetch the next column so its data lands on the next even cycle.
                rd_col = col_q + 1'b1;
                if (!half_q) begin
                    rgb_top_d = plane_bits(rd_data[2*PIX_W-1:PIX_W], bit_idx);
                    rgb_bot_d = plane_bits(rd_data[PIX_W-1:0], bit_idx);
                    half_d    = 1'b1;
                end else begin
                    clk_d  = 1'b1;
                    half_d = 1'b0;
                    col_d  = col_q + 1'b1;
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                lat_d      = 1'b1;
                row_addr_d = row_q;
                show_cnt_d = '0;
                state_d    = SHOW;
            end
            SHOW: begin
                oe_n_d     = 1'b0;
                show_cnt_d = show_cnt_q + 1'b1;
                if (show_cnt_q == show_len - 1'b1) begin
                    show_cnt_d = '0;
                    state_d    = FETCH;
                    if (plane_q == PLANE_W'(BITS - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                        if (row_q == ROW_W'(SCAN_ROWS - 1)) begin
                            done_d  = 1'b1;
                            front_d = ~display;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            show_cnt_q <= '0;
            half_q     <= 1'b0;
            front_q    <= 1'b0;
            rgb_top_q  <= '0;
            rgb_bot_q  <= '0;
            row_addr_q <= '0;
            clk_q      <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            show_cnt_q <= show_cnt_d;
            half_q     <= half_d;
            front_q    <= front_d;
            rgb_top_q  <= rgb_top_d;
            rgb_bot_q  <= rgb_bot_d;
            row_addr_q <= row_addr_d;
            clk_q      <= clk_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
            done_q     <= done_d;
        end
    end

    assign rgb_top    = rgb_top_q;
    assign rgb_bot    = rgb_bot_q;
    assign row_addr   = row_addr_q;
    assign panel_clk  = clk_q;
    assign panel_lat  = lat_q;
    assign panel_oe_n = oe_n_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_hub75_scanout.sv
// Directed bench for hub75_scanout: reset pins, buffer swap, scan timing,
// pixel mapping, BCM plane bits and mid-frame reset recovery.
module tb_hub75_scanout;

    logic        pixclk = 1'b0;
    logic        reset_n;
    logic [8:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic        wr_en;
    logic        display;
    logic [2:0]  rgb_top, rgb_bot, row_addr;
    logic        panel_clk, panel_lat, panel_oe_n, frame_done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    hub75_scanout #(.BITS(4), .BASE_TICKS(8)) dut (
        .pixclk     (pixclk),
        .reset_n    (reset_n),
        .wr_addr    (wr_addr),
        .wr_rgb     (wr_rgb),
        .wr_en      (wr_en),
        .display    (display),
        .rgb_top    (rgb_top),
        .rgb_bot    (rgb_bot),
        .row_addr   (row_addr),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_oe_n (panel_oe_n),
        .frame_done (frame_done)
    );

    always #5 pixclk = ~pixclk;

    // Per segment (segment = row*4 + plane) observations of one scanned frame.
    int unsigned rise_cnt [32];
    int unsigned lat_cnt  [32];
    int unsigned oe_cnt   [32];
    logic [2:0]  row_of   [32];
    logic [2:0]  top_s    [32][32];
    logic [2:0]  bot_s    [32][32];
    int unsigned frame_len, first_rise;
    logic        got_done, fd_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixclk);
        @(negedge pixclk);
    endtask

    task automatic write_px(input logic [8:0] a, input logic [23:0] d);
        wr_addr = a;
        wr_rgb  = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic capture(input int unsigned flip_cyc, input logic flip_val);
        int unsigned seg, cyc;
        logic prev_clk, prev_oe;
        for (int s = 0; s < 32; s++) begin
            rise_cnt[s] = 0;
            lat_cnt[s]  = 0;
            oe_cnt[s]   = 0;
            row_of[s]   = 3'bx;
            for (int c = 0; c < 32; c++) begin
                top_s[s][c] = 3'bx;
                bot_s[s][c] = 3'bx;
            end
        end
        seg = 0; cyc = 0; prev_clk = 1'b0; prev_oe = 1'b1;
        got_done = 1'b0; frame_len = 0; first_rise = 0; fd_first = 1'bx;
        while (!got_done && cyc < 4000) begin
            tick();
            cyc++;
            if (cyc == flip_cyc) display = flip_val;
            if (cyc == 1) fd_first = frame_done;
            if (!prev_oe && panel_oe_n) seg++;
            if (seg < 32) begin
                if (panel_clk && !prev_clk) begin
                    if (rise_cnt[seg] < 32) begin
                        top_s[seg][rise_cnt[seg]] = rgb_top;
                        bot_s[seg][rise_cnt[seg]] = rgb_bot;
                    end
                    rise_cnt[seg]++;
                    if (first_rise == 0) first_rise = cyc;
                end
                if (panel_lat) lat_cnt[seg]++;
                if (!panel_oe_n) begin
                    oe_cnt[seg]++;
                    row_of[seg] = row_addr;
                end
            end
            if (frame_done) begin
                got_done  = 1'b1;
                frame_len = cyc;
            end
            prev_clk = panel_clk;
            prev_oe  = panel_oe_n;
        end
    endtask

    // mode 0: all dark, 1: all white, 2: the two test pixels only
    task automatic check_frame(input int mode);
        logic [3:0]  red_planes;
        logic [2:0]  et, eb;
        int unsigned row, plane;
        red_planes = 4'b0101;
        chk($sformatf("m%0d frame_done_seen", mode), 32'(got_done), 32'd1);
        chk($sformatf("m%0d frame_len", mode), frame_len, 32'd3072);
        chk($sformatf("m%0d first_clk_rise", mode), first_rise, 32'd3);
        chk($sformatf("m%0d frame_done_pulse", mode), 32'(fd_first), 32'd0);
        for (int s = 0; s < 32; s++) begin
            row   = s / 4;
            plane = s % 4;
            chk($sformatf("m%0d s%0d clk_rises", mode, s), rise_cnt[s], 32'd32);
            chk($sformatf("m%0d s%0d lat_cycles", mode, s), lat_cnt[s], 32'd1);
            chk($sformatf("m%0d s%0d oe_cycles", mode, s), oe_cnt[s], 32'd8 << plane);
            chk($sformatf("m%0d s%0d row_addr", mode, s), 32'(row_of[s]), row);
            for (int c = 0; c < 32; c++) begin
                et = 3'b000;
                eb = 3'b000;
                if (mode == 1) begin
                    et = 3'b111;
                    eb = 3'b111;
                end else if (mode == 2) begin
                    if (row == 2 && c == 9 && red_planes[plane]) et = 3'b100;
                    if (row == 5 && c == 5) eb = 3'b100;
                end
                chk($sformatf("m%0d s%0d c%0d rgb_top", mode, s, c), 32'(top_s[s][c]), 32'(et));
                chk($sformatf("m%0d s%0d c%0d rgb_bot", mode, s, c), 32'(bot_s[s][c]), 32'(eb));
            end
        end
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, " oe_n"}, 32'(panel_oe_n), 32'd1);
        chk({tag, " lat"}, 32'(panel_lat), 32'd0);
        chk({tag, " panel_clk"}, 32'(panel_clk), 32'd0);
        chk({tag, " row_addr"}, 32'(row_addr), 32'd0);
        chk({tag, " rgb_top"}, 32'(rgb_top), 32'd0);
        chk({tag, " rgb_bot"}, 32'(rgb_bot), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int unsigned waited;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_rgb  = '0;
        display = 1'b0;
        @(negedge pixclk);

        // Under reset: clear buffer 0, fill buffer 1 white.
        for (int a = 0; a < 512; a++) write_px(9'(a), 24'h000000);
        display = 1'b1;
        for (int a = 0; a < 512; a++) write_px(9'(a), 24'hFFFFFF);
        tick(); tick(); tick();
        chk_reset_pins("rst");

        // Frame A: front is buffer 0; writer toggles to 0 mid-frame.
        reset_n = 1'b1;
        capture(1000, 1'b0);
        check_frame(0);

        // Frame B: swap took effect, buffer 1 shown.
        capture(0, 1'b0);
        check_frame(1);

        // Test pixels into buffer 0 while it is the back buffer.
        write_px(9'h1A5, 24'hF00000);
        write_px(9'h049, 24'h500000);
        display = 1'b1;

        waited = 0;
        while (!(row_addr == 3'd4 && !panel_oe_n) && waited < 4000) begin
            tick();
            waited++;
        end
        chk("reach_row4_show", 32'(waited < 4000), 32'd1);
        reset_n = 1'b0;
        tick(); tick();
        chk_reset_pins("midrst");

        // Frame C: restart after reset, front back to buffer 0.
        reset_n = 1'b1;
        capture(0, 1'b0);
        check_frame(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
